// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - pipeline hazard, flush, freeze and halt controller (optional stall counter: HAZARD_STALL_CNT_EN)
module pipe_hazard_ctrl #(
    parameter int MDU_LAT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_use_rs,
    input  logic        id_use_rt,
    input  logic [4:0]  ex_wbreg,
    input  logic        ex_regwrite,
    input  logic        ex_memtoreg,
    input  logic        br_taken_ex,
    input  logic        mdu_start_ex,
    input  logic        syscall_halt_ex,
    input  logic        resume,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        ifid_clr,
    output logic        idex_en,
    output logic        idex_clr,
    output logic        idex_bb,
    output logic        exmem_en,
    output logic        halted,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MDU_BUSY = 2'd1,
        MDU_DONE = 2'd2,
        HALT     = 2'd3
    } state_t;

    // Busy cycles after the triggering RUN cycle; the RUN cycle is the first freeze cycle.
    localparam logic [3:0] MDU_LOAD = 4'(MDU_LAT - 2);

    state_t     state;
    logic [3:0] cnt;

    logic freeze;
    logic sys_ev;
    logic br_ev;
    logic lu_hit;
    logic lu_ev;

    // Event decode in priority order: freeze, syscall halt, branch flush, load-use.
    always_comb begin
        freeze = (state == MDU_BUSY) || (state == HALT) ||
                 ((state == RUN) && mdu_start_ex);
        lu_hit = ex_memtoreg && ex_regwrite && (ex_wbreg != 5'd0) &&
                 ((id_use_rs && (id_rs == ex_wbreg)) ||
                  (id_use_rt && (id_rt == ex_wbreg)));
        sys_ev = !freeze && syscall_halt_ex;
        br_ev  = !freeze && !syscall_halt_ex && br_taken_ex;
        lu_ev  = !freeze && !syscall_halt_ex && !br_taken_ex && lu_hit;
    end

    // Pipeline register controls; reset holds every stage and clears the front end.
    always_comb begin
        pc_en    = 1'b1;
        ifid_en  = 1'b1;
        ifid_clr = 1'b0;
        idex_en  = 1'b1;
        idex_clr = 1'b0;
        idex_bb  = 1'b0;
        exmem_en = 1'b1;
        halted   = 1'b0;
        if (rst) begin
            pc_en    = 1'b0;
            ifid_en  = 1'b0;
            idex_en  = 1'b0;
            exmem_en = 1'b0;
            ifid_clr = 1'b1;
            idex_clr = 1'b1;
        end else begin
            halted = (state == HALT);
            if (freeze) begin
                pc_en    = 1'b0;
                ifid_en  = 1'b0;
                idex_en  = 1'b0;
                exmem_en = 1'b0;
            end else if (sys_ev) begin
                pc_en    = 1'b0;
                ifid_clr = 1'b1;
                idex_clr = 1'b1;
            end else if (br_ev) begin
                ifid_clr = 1'b1;
                idex_clr = 1'b1;
            end else if (lu_ev) begin
                pc_en   = 1'b0;
                ifid_en = 1'b0;
                idex_bb = 1'b1;
            end
        end
    end

    // Control FSM: MDU freeze countdown, one-cycle MDU_DONE guard, halt/resume.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= RUN;
            cnt   <= 4'd0;
        end else begin
            case (state)
                RUN: begin
                    if (mdu_start_ex) begin
                        cnt   <= MDU_LOAD;
                        state <= MDU_BUSY;
                    end else if (syscall_halt_ex) begin
                        state <= HALT;
                    end
                end
                MDU_BUSY: begin
                    if (cnt == 4'd0) begin
                        state <= MDU_DONE;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                MDU_DONE: begin
                    // mdu_start_ex still reflects the finished instruction here, so it is ignored.
                    if (syscall_halt_ex) begin
                        state <= HALT;
                    end else begin
                        state <= RUN;
                    end
                end
                HALT: begin
                    if (resume) begin
                        state <= RUN;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

`ifdef HAZARD_STALL_CNT_EN
    logic [31:0] stall_q;

    // Count front-end stall cycles outside HALT, saturating at all ones.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_q <= 32'd0;
        end else if (!pc_en && (state != HALT) && (stall_q != 32'hFFFF_FFFF)) begin
            stall_q <= stall_q + 32'd1;
        end
    end

    assign stall_cycles = stall_q;
`else
    assign stall_cycles = 32'd0;
`endif

endmodule
